// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage MIPS pipeline (PC, IF/ID, ID/EX,
//   EX/MEM, MEM/WB). It owns no data. It drives an active-low load enable for
//   every pipeline register and inserts bubbles for four cases: load-use
//   hazards, multi-cycle mult/div ops, data-memory wait states and taken
//   branches. Priority: mem_busy > MDU > load-use > taken branch.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   id_rs, id_rt      source specifiers of the instruction in ID
//   id_use_rs/_rt     ID instruction actually reads rs / rt
//   ex_mem_read       instruction in EX is a load
//   ex_rd             destination of the instruction in EX
//   id_mdu_start      ID instruction is a mult/div
//   mem_busy          data memory not ready; MEM must hold
//   id_branch_tkn     branch resolved taken in ID
//   *_en_bar          0 = pipeline register loads this cycle
//   ifid_flush        IF/ID loads a NOP
//   idex_flush        ID/EX loads a NOP (bubble)
//   mdu_busy          mult/div op in progress
//   stall_cnt         saturating count of cycles with pc_en_bar=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_mdu_start,
    input  logic             mem_busy,
    input  logic             id_branch_tkn,
    output logic             pc_en_bar,
    output logic             ifid_en_bar,
    output logic             idex_en_bar,
    output logic             exmem_en_bar,
    output logic             memwb_en_bar,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Enough bits to hold MDU_LAT-1 (MDU_LAT >= 2).
    localparam int MC_W = $clog2(MDU_LAT);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MDU  = 2'd1,
        MEMW = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [MC_W-1:0] mdu_cnt, mdu_cnt_nxt;
    logic            lu;
    logic            run_like;
    logic            mdu_go;

    // Load-use hazard; $0 is hard-wired zero and never creates a dependency.
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // MEMW releasing (mem_busy low) acts like RUN for this cycle.
    assign run_like = (state == RUN) || (state == MEMW);

    // A new mult/div may only issue when no earlier op is parked in MEMW.
    assign mdu_go = run_like && !mem_busy && id_mdu_start && !lu && (mdu_cnt == '0);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        if (mem_busy) begin
            // Counter frozen; MEMW remembers the MDU op through mdu_cnt != 0.
            state_nxt = MEMW;
        end else begin
            case (state)
                MDU: begin
                    mdu_cnt_nxt = mdu_cnt - 1'b1;
                    if (mdu_cnt <= MC_W'(1)) state_nxt = RUN;
                end
                default: begin
                    if (mdu_go) begin
                        state_nxt   = MDU;
                        mdu_cnt_nxt = MC_W'(MDU_LAT - 1);
                    end else begin
                        state_nxt = (mdu_cnt != '0) ? MDU : RUN;
                    end
                end
            endcase
        end
    end

    // Mealy outputs: state plus current hazard inputs.
    always_comb begin
        pc_en_bar    = 1'b0;
        ifid_en_bar  = 1'b0;
        idex_en_bar  = 1'b0;
        exmem_en_bar = 1'b0;
        memwb_en_bar = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        if (rst) begin
            pc_en_bar    = 1'b1;
            ifid_en_bar  = 1'b1;
            idex_en_bar  = 1'b1;
            exmem_en_bar = 1'b1;
            memwb_en_bar = 1'b1;
        end else if (mem_busy || (state == MDU)) begin
            // Freeze the front of the pipe; MEM/WB keeps draining (a NOP slot
            // while memory waits, the older instruction during an MDU op).
            pc_en_bar    = 1'b1;
            ifid_en_bar  = 1'b1;
            idex_en_bar  = 1'b1;
            exmem_en_bar = 1'b1;
        end else if (lu) begin
            // Hold PC and IF/ID, drop one bubble into ID/EX. A simultaneous
            // taken branch is re-evaluated next cycle.
            pc_en_bar   = 1'b1;
            ifid_en_bar = 1'b1;
            idex_flush  = 1'b1;
        end else if (!mdu_go && id_branch_tkn) begin
            ifid_flush = 1'b1;
        end
    end

    assign mdu_busy = (state == MDU) || ((state == MEMW) && (mdu_cnt != '0));

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_en_bar && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
